// File: rtl/simplebus_pkg.sv
// Shared definitions for the simplebus master.
// Holds the command and ack byte codes, the frame field sizes, the
// controller state encoding and a parity helper.
package simplebus_pkg;

   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] CMD_WRITE = 8'h03;
   localparam logic [7:0] READ_ACK  = 8'h82;
   localparam logic [7:0] WRITE_ACK = 8'h83;

   localparam int ADDR_BYTES      = 4;
   localparam int DATA_BYTES      = 8;
   localparam int READ_FRAME_LEN  = 1 + ADDR_BYTES;
   localparam int WRITE_FRAME_LEN = 1 + ADDR_BYTES + 1 + DATA_BYTES;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND     = 3'd1,
      ST_WAIT_RSP = 3'd2,
      ST_RECV     = 3'd3,
      ST_DONE     = 3'd4,
      ST_ERR      = 3'd5
   } state_t;

   // The bus uses odd parity: the parity bit is the XNOR of the data byte.
   function automatic logic parity_ok(input logic [7:0] b, input logic p);
      return p == ~^b;
   endfunction

endpackage

// File: rtl/simplebus_rr_arbiter.sv
// Round-robin grant selection for the simplebus master.
// Ports:
//   req_valid  in  NUM_REQ  pending requests
//   last_grant in  GW       index of the most recently served requester
//   grant      out GW       first valid index searching upward from last_grant+1
//   any_valid  out 1        at least one request is pending
module simplebus_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int GW      = 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [GW-1:0]      last_grant,
   output logic [GW-1:0]      grant,
   output logic               any_valid
);

   logic [GW-1:0] w_cand;

   // Walk the requesters starting just after the last winner; the last
   // candidate tried is last_grant itself, so a lone requester can win again.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      w_cand    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = GW'((int'(last_grant) + k) % NUM_REQ);
         if (!any_valid && req_valid[w_cand]) begin
            any_valid = 1'b1;
            grant     = w_cand;
         end
      end
   end

endmodule

// File: rtl/simplebus_master_arb.sv
// Master-side controller for the 8-bit odd-parity simplebus.
// Arbitrates round-robin between NUM_REQ requesters, serialises the granted
// request as a command frame, waits for the slave response and returns a
// one-cycle ack (with read data) or error pulse to the granted requester.
// Ports:
//   clk, resetb                      clock, asynchronous active-low reset
//   req_valid/we/addr/sel/wdata      per-requester request, packed per index
//   resp_ack, resp_err               one-cycle completion pulses
//   resp_rdata                       last completed read data
//   bus_out, bus_pty_out             byte and odd parity driven to the slave
//   bus_in, bus_pty_in               byte and parity from the slave
//   busy                             controller is not idle
module simplebus_master_arb #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_we,
   input  logic [32*NUM_REQ-1:0]   req_addr,
   input  logic [8*NUM_REQ-1:0]    req_sel,
   input  logic [64*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      resp_ack,
   output logic [NUM_REQ-1:0]      resp_err,
   output logic [63:0]             resp_rdata,
   output logic [7:0]              bus_out,
   output logic                    bus_pty_out,
   input  logic [7:0]              bus_in,
   input  logic                    bus_pty_in,
   output logic                    busy
);
   import simplebus_pkg::*;

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               r_state;
   logic [GW-1:0]        r_grant, r_last_grant;
   logic                 r_we;
   logic [31:0]          r_addr;
   logic [7:0]           r_sel;
   logic [63:0]          r_wdata;
   logic [3:0]           r_idx;
   logic [7:0]           r_timer;
   logic [55:0]          r_shift;
   logic [63:0]          r_rdata;
   logic [7:0]           r_bus_out;
   logic [NUM_REQ-1:0]   r_resp_ack, r_resp_err;

   logic [31:0]          w_addr  [NUM_REQ];
   logic [7:0]           w_sel   [NUM_REQ];
   logic [63:0]          w_wdata [NUM_REQ];
   logic [GW-1:0]        w_grant;
   logic                 w_any;
   logic [NUM_REQ-1:0]   w_grant_oh;
   logic [7:0]           w_frame_byte;
   logic [1:0]           w_a_i;
   logic [2:0]           w_d_i;
   logic [3:0]           w_len;
   logic [7:0]           w_exp_ack;
   logic                 w_pty_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_addr[gi]  = req_addr[32*gi +: 32];
         assign w_sel[gi]   = req_sel[8*gi +: 8];
         assign w_wdata[gi] = req_wdata[64*gi +: 64];
      end
   endgenerate

   simplebus_rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_arb (
      .req_valid  (req_valid),
      .last_grant (r_last_grant),
      .grant      (w_grant),
      .any_valid  (w_any)
   );

   assign w_grant_oh = NUM_REQ'(1) << r_grant;
   assign w_len      = r_we ? 4'(WRITE_FRAME_LEN) : 4'(READ_FRAME_LEN);
   assign w_exp_ack  = r_we ? WRITE_ACK : READ_ACK;
   assign w_pty_ok   = parity_ok(bus_in, bus_pty_in);

   // Frame byte r_idx: command, 4 address bytes, then (writes only) the
   // byte-select and 8 data bytes, each multi-byte field LSB first.
   always_comb begin
      w_a_i        = 2'(r_idx - 4'd1);
      w_d_i        = 3'(r_idx - 4'd6);
      w_frame_byte = 8'h00;
      if (r_idx == 4'd0)
         w_frame_byte = r_we ? CMD_WRITE : CMD_READ;
      else if (r_idx <= 4'd4)
         w_frame_byte = r_addr[{w_a_i, 3'b000} +: 8];
      else if (r_idx == 4'd5)
         w_frame_byte = r_sel;
      else
         w_frame_byte = r_wdata[{w_d_i, 3'b000} +: 8];
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_sel        <= '0;
         r_wdata      <= '0;
         r_idx        <= '0;
         r_timer      <= '0;
         r_shift      <= '0;
         r_rdata      <= '0;
         r_bus_out    <= '0;
         r_resp_ack   <= '0;
         r_resp_err   <= '0;
      end else begin
         // Pulses are raised on entry to DONE/ERR and dropped the cycle after.
         r_resp_ack <= '0;
         r_resp_err <= '0;
         case (r_state)
            ST_IDLE: begin
               r_bus_out <= 8'h00;
               if (w_any) begin
                  r_grant <= w_grant;
                  r_we    <= req_we[w_grant];
                  r_addr  <= w_addr[w_grant];
                  r_sel   <= w_sel[w_grant];
                  r_wdata <= w_wdata[w_grant];
                  r_idx   <= '0;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (r_idx == w_len) begin
                  r_bus_out <= 8'h00;
                  r_timer   <= '0;
                  r_state   <= ST_WAIT_RSP;
               end else begin
                  r_bus_out <= w_frame_byte;
                  r_idx     <= r_idx + 4'd1;
               end
            end
            ST_WAIT_RSP: begin
               if (!w_pty_ok) begin
                  r_resp_err <= w_grant_oh;
                  r_state    <= ST_ERR;
               end else if (bus_in == 8'h00) begin
                  if (r_timer == 8'(TIMEOUT_CYCLES - 1)) begin
                     r_resp_err <= w_grant_oh;
                     r_state    <= ST_ERR;
                  end else begin
                     r_timer <= r_timer + 8'd1;
                  end
               end else if (bus_in == w_exp_ack) begin
                  if (r_we) begin
                     r_resp_ack <= w_grant_oh;
                     r_state    <= ST_DONE;
                  end else begin
                     r_idx   <= '0;
                     r_state <= ST_RECV;
                  end
               end else begin
                  r_resp_err <= w_grant_oh;
                  r_state    <= ST_ERR;
               end
            end
            ST_RECV: begin
               if (!w_pty_ok) begin
                  r_resp_err <= w_grant_oh;
                  r_state    <= ST_ERR;
               end else if (r_idx == 4'd7) begin
                  // Earlier bytes sit in r_shift with byte 0 at the bottom.
                  r_rdata    <= {bus_in, r_shift};
                  r_resp_ack <= w_grant_oh;
                  r_state    <= ST_DONE;
               end else begin
                  r_shift <= {bus_in, r_shift[55:8]};
                  r_idx   <= r_idx + 4'd1;
               end
            end
            ST_DONE, ST_ERR: begin
               r_last_grant <= r_grant;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign resp_ack    = r_resp_ack;
   assign resp_err    = r_resp_err;
   assign resp_rdata  = r_rdata;
   assign bus_out     = r_bus_out;
   assign bus_pty_out = ~^r_bus_out;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_simplebus_master_arb.sv
// Self-checking bench for simplebus_master_arb: a requester/slave model
// predicts grants, frames, pulse timing and read data.
module tb_simplebus_master_arb;
   localparam int NR   = 2;
   localparam int TO   = 255;
   localparam int WLEN = 14;
   localparam int RLEN = 5;

   logic              clk = 1'b0;
   logic              resetb;
   logic [NR-1:0]     req_valid, req_we;
   logic [32*NR-1:0]  req_addr;
   logic [8*NR-1:0]   req_sel;
   logic [64*NR-1:0]  req_wdata;
   logic [NR-1:0]     resp_ack, resp_err;
   logic [63:0]       resp_rdata;
   logic [7:0]        bus_out, bus_in;
   logic              bus_pty_out, bus_pty_in, busy;

   always #5 clk = ~clk;

   simplebus_master_arb #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetb(resetb), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
      .resp_ack(resp_ack), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .bus_out(bus_out), .bus_pty_out(bus_pty_out), .bus_in(bus_in),
      .bus_pty_in(bus_pty_in), .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // requester model
   bit          m_we    [NR];
   logic [31:0] m_addr  [NR];
   logic [7:0]  m_sel   [NR];
   logic [63:0] m_wdata [NR];
   bit [NR-1:0] m_pending = '0;
   int          m_last    = 0;
   logic [63:0] m_rdata   = '0;

   logic [8:0]  rsp_q[$];      // {parity, byte} fed to the DUT after the frame
   logic [7:0]  exp_frame[$];

   // observations of one served transaction
   logic [7:0]  obs_frame[$];
   int          obs_cycle;
   logic [NR-1:0] obs_ack, obs_err;
   logic [63:0] obs_rdata;
   int          obs_pulses;
   bit          obs_bus_nz;

   task automatic set_req(input int r, input bit we, input logic [31:0] a,
                          input logic [7:0] s, input logic [63:0] d);
      m_we[r] = we; m_addr[r] = a; m_sel[r] = s; m_wdata[r] = d;
      m_pending[r] = 1'b1;
      req_we[r] = we;
      req_addr[32*r +: 32]  = a;
      req_sel[8*r +: 8]     = s;
      req_wdata[64*r +: 64] = d;
      req_valid = m_pending;
   endtask

   function automatic int rr_pick();
      for (int k = 1; k <= NR; k++)
         if (m_pending[(m_last + k) % NR]) return (m_last + k) % NR;
      return -1;
   endfunction

   function automatic void build_frame(input int r);
      exp_frame.delete();
      exp_frame.push_back(m_we[r] ? 8'h03 : 8'h02);
      for (int i = 0; i < 4; i++) exp_frame.push_back(8'(m_addr[r] >> (8*i)));
      if (m_we[r]) begin
         exp_frame.push_back(m_sel[r]);
         for (int i = 0; i < 8; i++) exp_frame.push_back(8'(m_wdata[r] >> (8*i)));
      end
   endfunction

   task automatic push_rsp(input logic [7:0] b, input bit bad);
      rsp_q.push_back({bad ? ^b : ~^b, b});
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push_rsp(8'h00, 1'b0);
   endtask

   // Queue idle bytes, the correct ack and (reads) 8 random data bytes;
   // returns the read data those bytes should assemble to.
   task automatic queue_response(input int r, input int delay, output logic [63:0] rd);
      logic [7:0] b;
      rd = '0;
      push_idle(delay);
      push_rsp(m_we[r] ? 8'h83 : 8'h82, 1'b0);
      if (!m_we[r])
         for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            rd = rd | (64'(b) << (8*i));
            push_rsp(b, 1'b0);
         end
   endtask

   // Drive one transaction of requester r to completion. Cycle 0 is the first
   // cycle busy is seen; frame bytes occupy cycles 1..len; slave bytes start
   // with the cycle after the frame.
   task automatic serve(input int r, input int max_cycles);
      int c, len, stop;
      logic [8:0] t;
      c = -1; stop = -1;
      len = m_we[r] ? WLEN : RLEN;
      obs_frame.delete();
      obs_cycle = -1; obs_ack = '0; obs_err = '0; obs_rdata = '0;
      obs_pulses = 0; obs_bus_nz = 1'b0;
      for (int n = 0; n < max_cycles; n++) begin
         @(negedge clk);
         if (c < 0) begin
            if (busy) c = 0;
         end else c++;
         if (c >= 1 && c <= len) obs_frame.push_back(bus_out);
         else if (c > len && bus_out !== 8'h00) obs_bus_nz = 1'b1;
         if ((resp_ack | resp_err) !== '0) begin
            obs_pulses++;
            if (obs_cycle < 0) begin
               obs_cycle = c; obs_ack = resp_ack; obs_err = resp_err;
               obs_rdata = resp_rdata;
               m_pending[r] = 1'b0;
               req_valid = m_pending;
               stop = n + 1;
            end
         end
         if (c >= len + 1 && rsp_q.size() > 0) begin
            t = rsp_q.pop_front();
            bus_in = t[7:0]; bus_pty_in = t[8];
         end else begin
            bus_in = 8'h00; bus_pty_in = 1'b1;
         end
         if (n == stop) break;
      end
      rsp_q.delete();
      bus_in = 8'h00; bus_pty_in = 1'b1;
   endtask

   task automatic test_reset();
      resetb = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_sel = '0;
      req_wdata = '0; bus_in = 8'h00; bus_pty_in = 1'b1;
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
      n_checks++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus_out: got %h expected 00", bus_out); end
      n_checks++; if (bus_pty_out !== 1'b1) begin n_fail++; $display("FAIL reset_bus_pty: got %b expected 1", bus_pty_out); end
      n_checks++; if (resp_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", resp_ack); end
      n_checks++; if (resp_err !== '0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err); end
      n_checks++; if (resp_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      $display("reset: bus_out=%h pty=%b busy=%b", bus_out, bus_pty_out, busy);
   endtask

   task automatic test_write_directed();
      int r; bit bad;
      set_req(0, 1'b1, 32'h12345678, 8'hFF, 64'h1122334455667788);
      r = rr_pick();
      build_frame(r);
      push_idle(3); push_rsp(8'h83, 1'b0);
      serve(r, 100);
      bad = (obs_frame.size() != exp_frame.size());
      for (int i = 0; i < obs_frame.size() && i < exp_frame.size(); i++)
         if (obs_frame[i] !== exp_frame[i]) bad = 1'b1;
      n_checks++; if (bad) begin n_fail++; $display("FAIL wr_frame: got %p expected %p", obs_frame, exp_frame); end
      n_checks++; if (obs_ack !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got %b expected 01", obs_ack); end
      n_checks++; if (obs_err !== 2'b00) begin n_fail++; $display("FAIL wr_err: got %b expected 00", obs_err); end
      n_checks++; if (obs_pulses != 1) begin n_fail++; $display("FAIL wr_pulse_width: got %0d expected 1", obs_pulses); end
      n_checks++; if (obs_cycle != 19) begin n_fail++; $display("FAIL wr_latency: got %0d expected 19", obs_cycle); end
      n_checks++; if (obs_rdata !== m_rdata) begin n_fail++; $display("FAIL wr_rdata: got %h expected %h", obs_rdata, m_rdata); end
      n_checks++; if (obs_bus_nz) begin n_fail++; $display("FAIL wr_bus_idle: got nonzero expected 00"); end
      m_last = r;
      $display("write req0: ack=%b err=%b cycle=%0d", obs_ack, obs_err, obs_cycle);
   endtask

   task automatic test_read_directed();
      int r;
      set_req(1, 1'b0, 32'h00001000, 8'($urandom), {$urandom, $urandom});
      r = rr_pick();
      push_idle(8); push_rsp(8'h82, 1'b0);
      for (int b = 8; b >= 1; b--) push_rsp(8'(b), 1'b0);
      serve(r, 100);
      n_checks++; if (obs_ack !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got %b expected 10", obs_ack); end
      n_checks++; if (obs_rdata !== 64'h0102030405060708) begin n_fail++; $display("FAIL rd_rdata: got %h expected 0102030405060708", obs_rdata); end
      n_checks++; if (obs_cycle != 23) begin n_fail++; $display("FAIL rd_latency: got %0d expected 23", obs_cycle); end
      m_last = r; m_rdata = 64'h0102030405060708;
      $display("read req1: ack=%b rdata=%h cycle=%0d", obs_ack, obs_rdata, obs_cycle);
   endtask

   task automatic test_random_txns();
      int r, d, ec; bit bad; logic [63:0] rd, er;
      for (int t = 0; t < 8; t++) begin
         set_req($urandom_range(0, NR-1), 1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom});
         r = rr_pick();
         build_frame(r);
         d = $urandom_range(0, 12);
         queue_response(r, d, rd);
         ec = (m_we[r] ? WLEN : RLEN) + d + 2 + (m_we[r] ? 0 : 8);
         er = m_we[r] ? m_rdata : rd;
         serve(r, 100);
         bad = (obs_frame.size() != exp_frame.size());
         for (int i = 0; i < obs_frame.size() && i < exp_frame.size(); i++)
            if (obs_frame[i] !== exp_frame[i]) bad = 1'b1;
         n_checks++; if (bad) begin n_fail++; $display("FAIL rnd_frame[%0d]: got %p expected %p", t, obs_frame, exp_frame); end
         n_checks++; if (obs_ack !== NR'(1 << r) || obs_err !== '0) begin n_fail++; $display("FAIL rnd_pulse[%0d]: got ack=%b err=%b expected ack=%b", t, obs_ack, obs_err, NR'(1 << r)); end
         n_checks++; if (obs_cycle != ec) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, obs_cycle, ec); end
         n_checks++; if (obs_rdata !== er) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", t, obs_rdata, er); end
         m_last = r; m_rdata = er;
         $display("random %0d: req%0d we=%0d ack=%b rdata=%h cycle=%0d", t, r, m_we[r], obs_ack, obs_rdata, obs_cycle);
      end
   endtask

   task automatic test_round_robin();
      int r; bit bad; logic [63:0] rd;
      for (int i = 0; i < NR; i++) set_req(i, 1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom});
      for (int t = 0; t < 6; t++) begin
         r = rr_pick();
         build_frame(r);
         queue_response(r, $urandom_range(0, 4), rd);
         serve(r, 100);
         bad = (obs_frame.size() != exp_frame.size());
         for (int i = 0; i < obs_frame.size() && i < exp_frame.size(); i++)
            if (obs_frame[i] !== exp_frame[i]) bad = 1'b1;
         n_checks++; if (obs_ack !== NR'(1 << r)) begin n_fail++; $display("FAIL rr_grant[%0d]: got ack=%b expected %b", t, obs_ack, NR'(1 << r)); end
         n_checks++; if (bad) begin n_fail++; $display("FAIL rr_frame[%0d]: got %p expected %p", t, obs_frame, exp_frame); end
         if (!m_we[r]) m_rdata = rd;
         m_last = r;
         $display("round robin %0d: granted req%0d ack=%b", t, r, obs_ack);
         if (t < 4) set_req(r, 1'($urandom), $urandom, 8'($urandom), {$urandom, $urandom});
      end
   endtask

   task automatic test_timeout();
      int r;
      set_req(0, 1'b0, $urandom, 8'h00, 64'h0);
      r = rr_pick();
      serve(r, 400);
      n_checks++; if (obs_err !== NR'(1 << r) || obs_ack !== '0) begin n_fail++; $display("FAIL to_pulse: got ack=%b err=%b expected err=%b", obs_ack, obs_err, NR'(1 << r)); end
      n_checks++; if (obs_cycle != RLEN + TO + 1) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", obs_cycle, RLEN + TO + 1); end
      n_checks++; if (obs_rdata !== m_rdata) begin n_fail++; $display("FAIL to_rdata: got %h expected %h", obs_rdata, m_rdata); end
      m_last = r;
      $display("timeout: err=%b cycle=%0d", obs_err, obs_cycle);
   endtask

   task automatic test_parity_err();
      int r;
      set_req(1, 1'b0, $urandom, 8'h00, 64'h0);
      r = rr_pick();
      push_idle(2); push_rsp(8'h82, 1'b0);
      for (int i = 1; i <= 8; i++) push_rsp(8'($urandom), i == 4);
      serve(r, 100);
      n_checks++; if (obs_err !== NR'(1 << r) || obs_ack !== '0) begin n_fail++; $display("FAIL pty_pulse: got ack=%b err=%b expected err=%b", obs_ack, obs_err, NR'(1 << r)); end
      n_checks++; if (obs_cycle != RLEN + 3 + 5) begin n_fail++; $display("FAIL pty_latency: got %0d expected %0d", obs_cycle, RLEN + 8); end
      n_checks++; if (obs_pulses != 1) begin n_fail++; $display("FAIL pty_pulse_width: got %0d expected 1", obs_pulses); end
      n_checks++; if (obs_rdata !== m_rdata) begin n_fail++; $display("FAIL pty_rdata: got %h expected %h", obs_rdata, m_rdata); end
      m_last = r;
      $display("parity error: err=%b cycle=%0d", obs_err, obs_cycle);
   endtask

   task automatic test_bad_ack();
      int f, r, d; bit bad; logic [63:0] rd;
      f = (m_last + 1) % NR;
      set_req(f, 1'b0, $urandom, 8'h00, 64'h0);
      set_req((f + 1) % NR, 1'b1, $urandom, 8'($urandom), {$urandom, $urandom});
      r = rr_pick();
      push_idle(1); push_rsp(8'h83, 1'b0);
      serve(r, 100);
      n_checks++; if (obs_err !== NR'(1 << f) || obs_ack !== '0) begin n_fail++; $display("FAIL badack_pulse: got ack=%b err=%b expected err=%b", obs_ack, obs_err, NR'(1 << f)); end
      n_checks++; if (obs_cycle != RLEN + 3) begin n_fail++; $display("FAIL badack_latency: got %0d expected %0d", obs_cycle, RLEN + 3); end
      m_last = r;
      r = rr_pick();
      build_frame(r);
      d = $urandom_range(0, 6);
      queue_response(r, d, rd);
      serve(r, 100);
      bad = (obs_frame.size() != exp_frame.size());
      for (int i = 0; i < obs_frame.size() && i < exp_frame.size(); i++)
         if (obs_frame[i] !== exp_frame[i]) bad = 1'b1;
      n_checks++; if (bad) begin n_fail++; $display("FAIL badack_next_frame: got %p expected %p", obs_frame, exp_frame); end
      n_checks++; if (obs_ack !== NR'(1 << r) || obs_err !== '0) begin n_fail++; $display("FAIL badack_next_ack: got ack=%b err=%b expected ack=%b", obs_ack, obs_err, NR'(1 << r)); end
      n_checks++; if (obs_cycle != WLEN + d + 2) begin n_fail++; $display("FAIL badack_next_latency: got %0d expected %0d", obs_cycle, WLEN + d + 2); end
      m_last = r;
      $display("bad ack then req%0d: ack=%b cycle=%0d", r, obs_ack, obs_cycle);
   endtask

   task automatic test_reset_mid_frame();
      int c, d; bit bad, pulsed; logic [63:0] rd;
      set_req(0, 1'b1, $urandom, 8'($urandom), {$urandom, $urandom});
      build_frame(0);
      c = -1;
      for (int n = 0; n < 40 && c < 7; n++) begin
         @(negedge clk);
         if (c < 0) begin
            if (busy) c = 0;
         end else c++;
      end
      n_checks++; if (c != 7 || bus_out !== exp_frame[6]) begin n_fail++; $display("FAIL rst_pre_byte6: got %h at cycle %0d expected %h", bus_out, c, exp_frame[6]); end
      #2 resetb = 1'b0;
      #1;
      n_checks++; if (bus_out !== 8'h00 || bus_pty_out !== 1'b1) begin n_fail++; $display("FAIL rst_async_bus: got %h/%b expected 00/1", bus_out, bus_pty_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
      pulsed = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if ((resp_ack | resp_err) !== '0) pulsed = 1'b1;
      end
      n_checks++; if (pulsed) begin n_fail++; $display("FAIL rst_no_pulse: got a pulse expected none"); end
      resetb = 1'b1;
      m_last = 0;
      d = $urandom_range(0, 5);
      queue_response(0, d, rd);
      serve(0, 100);
      bad = (obs_frame.size() != exp_frame.size());
      for (int i = 0; i < obs_frame.size() && i < exp_frame.size(); i++)
         if (obs_frame[i] !== exp_frame[i]) bad = 1'b1;
      n_checks++; if (bad) begin n_fail++; $display("FAIL rst_restart_frame: got %p expected %p", obs_frame, exp_frame); end
      n_checks++; if (obs_ack !== 2'b01 || obs_cycle != WLEN + d + 2) begin n_fail++; $display("FAIL rst_restart_ack: got ack=%b cycle=%0d expected ack=01 cycle=%0d", obs_ack, obs_cycle, WLEN + d + 2); end
      n_checks++; if (obs_rdata !== 64'h0) begin n_fail++; $display("FAIL rst_restart_rdata: got %h expected 0", obs_rdata); end
      $display("reset mid-frame: restart ack=%b cycle=%0d", obs_ack, obs_cycle);
   endtask

   initial begin
      test_reset();
      test_write_directed();
      test_read_directed();
      test_random_txns();
      test_round_robin();
      test_timeout();
      test_parity_err();
      test_bad_ack();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
